// File: rtl/fetch_pkg.sv
// Types and default widths shared by the fetch stage and the memory it drives.
package fetch_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int ADDR_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, memory read request FSM and the output word register
// presented to the decoder over a valid/ready handshake.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 WORD_SIZE = WORD_SIZE_DEF,
    parameter int                 ADDR_SIZE = ADDR_SIZE_DEF,
    parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 jmp_valid,
    input  logic [ADDR_SIZE-1:0] jmp_addr,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_oe,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [ADDR_SIZE-1:0] pc
);

    fetch_state_t         state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_oe_q, mem_oe_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [ADDR_SIZE-1:0] instr_pc_q, instr_pc_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 handshake;

    assign handshake = instr_valid_q & instr_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                instr_d       = mem_data;
                instr_pc_d    = pc_q;
                pc_d          = pc_q + 1'b1;
                instr_valid_d = 1'b1;
                state_d       = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    instr_valid_d = 1'b0;
                    state_d       = en ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect cancels any in-flight read; the captured word is dropped.
        if (jmp_valid) begin
            pc_d          = jmp_addr;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            state_d       = en ? REQ : IDLE;
        end
    end

    // Memory port is registered so it lines up with the REQ state.
    always_comb begin
        mem_oe_d   = (state_d == REQ);
        mem_addr_d = mem_addr_q;
        if (state_d == REQ) begin
            mem_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_addr_q    <= '0;
            mem_oe_q      <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_oe_q      <= mem_oe_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_oe      = mem_oe_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule
